// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with a one-byte command decoder (mode/sensor select, clear).
// Latency: 2 clk synchronizer; rx_done at mid stop bit; decoder outputs 1 clk after rx_done.
// No backpressure: rx_done/frame_err are single-cycle pulses; macro UART_CMD_DECODE_EN enables the decoder.
module uart_cmd_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       mode_sel,
  output logic       sensor_sel,
  output logic       clear
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        state_q, state_d;
  logic [3:0]    smp_cnt_q, smp_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic [7:0]    rx_data_d;
  logic          rx_done_d;
  logic          frame_err_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running 16x oversampling tick; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TW'(DIV - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TW'(DIV - 1));

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      brk_q     <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      rx_data   <= rx_data_d;
      rx_done   <= rx_done_d;
      frame_err <= frame_err_d;
    end
  end

  // Next-state logic: start bit checked mid-bit, data and stop sampled every 16 ticks after.
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    brk_d       = brk_q;
    rx_data_d   = rx_data;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        brk_d = 1'b0;
        if (!rx_s) begin
          state_d   = START;
          smp_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (smp_cnt_q == 4'd7) begin
            smp_cnt_d = '0;
            bit_cnt_d = '0;
            // A high line at mid start bit is a glitch: drop it silently.
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            smp_cnt_d = smp_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (smp_cnt_q == 4'd15) begin
            smp_cnt_d = '0;
            shift_d   = {rx_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (brk_q) begin
          // Line held low (break): wait for it to return high before re-arming.
          if (rx_s) begin
            state_d = IDLE;
            brk_d   = 1'b0;
          end
        end else if (tick) begin
          if (smp_cnt_q == 4'd15) begin
            smp_cnt_d = '0;
            if (rx_s) begin
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              brk_d       = 1'b1;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_CMD_DECODE_EN
  // Command decoder: acts on the byte the cycle after rx_done; framing errors never reach it.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_sel   <= 1'b0;
      sensor_sel <= 1'b0;
      clear      <= 1'b0;
    end else begin
      clear <= 1'b0;
      if (rx_done) begin
        case (rx_data)
          8'h55:   mode_sel   <= 1'b1;
          8'h54:   mode_sel   <= 1'b0;
          8'h53:   sensor_sel <= 1'b1;
          8'h57:   sensor_sel <= 1'b0;
          8'h52:   clear      <= 1'b1;
          default: ;
        endcase
      end
    end
  end
`else
  assign mode_sel   = 1'b0;
  assign sensor_sel = 1'b0;
  assign clear      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT      = DIV * 16;
`ifdef UART_CMD_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       mode_sel;
  logic       sensor_sel;
  logic       clear;

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .mode_sel   (mode_sel),
    .sensor_sel (sensor_sel),
    .clear      (clear)
  );

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         clear_cnt = 0;
  logic [7:0] exp_q[$];
  logic       last_done = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic       exp_mode = 1'b0;
  logic       exp_sensor = 1'b0;
  logic       exp_clear;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on rx_done and checks decoder outputs one clk later.
  always @(negedge clk) begin
    if (reset) begin
      exp_mode   = 1'b0;
      exp_sensor = 1'b0;
      last_done  = 1'b0;
    end else begin
      if (last_done) begin
        exp_clear = 1'b0;
        if (DEC) begin
          case (last_byte)
            8'h55: exp_mode = 1'b1;
            8'h54: exp_mode = 1'b0;
            8'h53: exp_sensor = 1'b1;
            8'h57: exp_sensor = 1'b0;
            8'h52: exp_clear = 1'b1;
            default: ;
          endcase
        end
        chk1("mode_sel_after_cmd", mode_sel, exp_mode);
        chk1("sensor_sel_after_cmd", sensor_sel, exp_sensor);
        chk1("clear_after_cmd", clear, exp_clear);
        last_done = 1'b0;
      end
      if (rx_done || frame_err) chk1("done_err_exclusive", rx_done & frame_err, 1'b0);
      if (rx_done) begin
        done_cnt++;
        chk1("rx_done_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("rx_data_scoreboard", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        last_done = 1'b1;
        last_byte = rx_data;
      end
      if (frame_err) ferr_cnt++;
      if (clear) clear_cnt++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_val;
    repeat (BIT * stop_bits) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 * BIT && done_cnt < target; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {24'd0, rx_data}, 32'd0);
    chk1(tag, rx_done, 1'b0);
    chk1(tag, frame_err, 1'b0);
    chk1(tag, mode_sel, 1'b0);
    chk1(tag, sensor_sel, 1'b0);
    chk1(tag, clear, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    // 'U' -> mode_sel 1
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1);
    wait_done(1);
    chk("done_cnt_U", done_cnt, 1);
    chk("rx_data_U", {24'd0, rx_data}, 32'h55);
    chk1("mode_sel_U", mode_sel, DEC);

    // 'T' then 'S' back-to-back
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h53);
    send_frame(8'h54, 1'b1, 1);
    send_frame(8'h53, 1'b1, 1);
    wait_done(3);
    chk("done_cnt_TS", done_cnt, 3);
    chk("rx_data_TS", {24'd0, rx_data}, 32'h53);
    chk1("mode_sel_TS", mode_sel, 1'b0);
    chk1("sensor_sel_TS", sensor_sel, DEC);

    // Start-bit glitch of 4 ticks
    rx = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("done_cnt_glitch", done_cnt, 3);
    chk("ferr_cnt_glitch", ferr_cnt, 0);

    // 'R' with stop bit held low for 2 bit periods, then a good 'R'
    send_frame(8'h52, 1'b0, 2);
    repeat (BIT) @(negedge clk);
    chk("ferr_cnt_break", ferr_cnt, 1);
    chk("done_cnt_break", done_cnt, 3);
    chk("rx_data_break", {24'd0, rx_data}, 32'h53);
    chk("clear_cnt_break", clear_cnt, 0);
    exp_q.push_back(8'h52);
    send_frame(8'h52, 1'b1, 1);
    wait_done(4);
    chk("done_cnt_R", done_cnt, 4);
    chk("clear_cnt_R", clear_cnt, DEC ? 1 : 0);
    chk("rx_data_R", {24'd0, rx_data}, 32'h52);

    // Reset during data bit 4 of 'W'
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 3) ? 1'b0 : 1'b1;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_midframe");
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    chk("done_cnt_abort", done_cnt, 4);
    chk("ferr_cnt_abort", ferr_cnt, 1);
    exp_q.push_back(8'h57);
    send_frame(8'h57, 1'b1, 1);
    wait_done(5);
    chk("done_cnt_W", done_cnt, 5);
    chk("rx_data_W", {24'd0, rx_data}, 32'h57);
    chk1("sensor_sel_W", sensor_sel, 1'b0);
    chk1("mode_sel_W", mode_sel, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
